fast_bconv_single: RTL and testbench



---
 rtl/fast_bconv_single.sv | 162 ++++++++++++++++
 tb/tb_fast_bconv_single.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fast_bconv_single.sv
// ============================================================================
// Module   : fast_bconv_single
// Brief    : RNS Fast-BConv engine, input basis q -> output basis B.
//            a_i = x_i*z_i mod q_i, then c_j = sum_i a_i*y_ji mod b_j.
//            Optional simulation trace/assertions: define FBCONV_TRACE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Fallback basis tables so the block elaborates on its own. Production builds
// define these macros from the generated q / qBBa basis header.
`ifndef q_BASIS_LEN
`define q_BASIS_LEN 3
`endif
`ifndef qBBa_BASIS_LEN
`define qBBa_BASIS_LEN 5
`endif
`ifndef q_BASIS
`define q_BASIS '{32'd7, 32'd11, 32'd13}
`endif
`ifndef qBBa_BASIS
`define qBBa_BASIS '{32'd7, 32'd11, 32'd13, 32'd17, 32'd19}
`endif
`ifndef z_MOD_q
`define z_MOD_q '{32'd5, 32'd4, 32'd12}
`endif
`ifndef y_q_TO_qBBa
`define y_q_TO_qBBa '{'{32'd3, 32'd0, 32'd0}, '{32'd0, 32'd3, 32'd0}, '{32'd0, 32'd0, 32'd12}, '{32'd7, 32'd6, 32'd9}, '{32'd10, 32'd15, 32'd1}}
`endif

module fast_bconv_single #(
  parameter int          IN_BASIS_LEN  = `q_BASIS_LEN,
  parameter int          OUT_BASIS_LEN = `qBBa_BASIS_LEN,
  parameter logic [31:0] IN_BASIS  [IN_BASIS_LEN]  = `q_BASIS,
  parameter logic [31:0] OUT_BASIS [OUT_BASIS_LEN] = `qBBa_BASIS,
  parameter logic [31:0] ZiLUT     [IN_BASIS_LEN]  = `z_MOD_q,
  parameter logic [31:0] YMODB     [OUT_BASIS_LEN][IN_BASIS_LEN] = `y_q_TO_qBBa
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] input_RNSint  [IN_BASIS_LEN],
  output logic        out_valid,
  output logic [31:0] output_RNSint [OUT_BASIS_LEN]
);

  localparam int c_IDX_W = (IN_BASIS_LEN > 1) ? $clog2(IN_BASIS_LEN) : 1;
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(IN_BASIS_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULZ  = 2'd1,
    ACCUM = 2'd2
  } state_t;

  state_t current_state;
  state_t next_state;

  logic [31:0]        r_x   [IN_BASIS_LEN];
  logic [31:0]        a_res [IN_BASIS_LEN];
  logic [31:0]        acc   [OUT_BASIS_LEN];
  logic [c_IDX_W-1:0] idx;

  logic               compute_is_active;
  logic               w_accept;
  logic               w_last;
  logic [31:0]        w_a_next   [IN_BASIS_LEN];
  logic [31:0]        w_acc_next [OUT_BASIS_LEN];
  logic [31:0]        w_a_sel;

  assign compute_is_active = (current_state != IDLE);
  assign w_accept          = in_valid && !compute_is_active;
  assign w_last            = (idx == c_IDX_LAST);
  assign w_a_sel           = a_res[idx];

  // a_i = x_i * z_i mod q_i, full 64-bit product before reduction
  for (genvar gi = 0; gi < IN_BASIS_LEN; gi++) begin : g_mulz
    logic [63:0] w_prod;
    assign w_prod       = {32'd0, r_x[gi]} * {32'd0, ZiLUT[gi]};
    assign w_a_next[gi] = 32'(w_prod % {32'd0, IN_BASIS[gi]});
  end

  // Each output lane folds in one input index per cycle.
  for (genvar gj = 0; gj < OUT_BASIS_LEN; gj++) begin : g_accum
    logic [63:0] w_prod;
    logic [31:0] w_psum;
    logic [32:0] w_sum;
    assign w_prod = {32'd0, w_a_sel} * {32'd0, YMODB[gj][idx]};
    assign w_psum = 32'(w_prod % {32'd0, OUT_BASIS[gj]});
    assign w_sum  = {1'b0, acc[gj]} + {1'b0, w_psum};
    assign w_acc_next[gj] = (w_sum >= {1'b0, OUT_BASIS[gj]})
                          ? 32'(w_sum - {1'b0, OUT_BASIS[gj]})
                          : w_sum[31:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      current_state <= IDLE;
    end else begin
      current_state <= next_state;
    end
  end

  always_comb begin
    next_state = current_state;
    case (current_state)
      IDLE:    if (w_accept) next_state = MULZ;
      MULZ:    next_state = ACCUM;
      ACCUM:   if (w_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x           <= '{default: '0};
      a_res         <= '{default: '0};
      acc           <= '{default: '0};
      idx           <= '0;
      out_valid     <= 1'b0;
      output_RNSint <= '{default: '0};
    end else begin
      out_valid <= 1'b0;
      case (current_state)
        IDLE: begin
          if (w_accept) r_x <= input_RNSint;
        end
        MULZ: begin
          a_res <= w_a_next;
          acc   <= '{default: '0};
          idx   <= '0;
        end
        ACCUM: begin
          acc <= w_acc_next;
          if (w_last) begin
            out_valid     <= 1'b1;
            output_RNSint <= w_acc_next;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FBCONV_TRACE_EN
  always @(posedge clk) begin
    $display("%0t state=%0d active=%0b a_res=%p out=%p", $time, current_state,
             compute_is_active, a_res, output_RNSint);
    if (!reset && w_accept) begin
      for (int i = 0; i < IN_BASIS_LEN; i++) begin
        assert (input_RNSint[i] < IN_BASIS[i])
          else $error("residue %0d out of range: %0d >= %0d", i, input_RNSint[i], IN_BASIS[i]);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fast_bconv_single.sv
// ============================================================================
// Module   : tb_fast_bconv_single
// Brief    : Directed self-checking bench for fast_bconv_single, small basis
//            q = {7,11,13} (Q = 1001) extended to B = {7,11,13,17,19}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fast_bconv_single;

  localparam int c_NI = 3;
  localparam int c_NO = 5;
  localparam int c_LAT = c_NI + 1;

  localparam logic [31:0] c_QB [c_NI] = '{32'd7, 32'd11, 32'd13};
  localparam logic [31:0] c_BB [c_NO] = '{32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
  localparam logic [31:0] c_ZB [c_NI] = '{32'd5, 32'd4, 32'd12};
  localparam logic [31:0] c_YB [c_NO][c_NI] = '{'{32'd3, 32'd0, 32'd0}, '{32'd0, 32'd3, 32'd0},
                                               '{32'd0, 32'd0, 32'd12}, '{32'd7, 32'd6, 32'd9},
                                               '{32'd10, 32'd15, 32'd1}};

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] input_RNSint  [c_NI];
  logic        out_valid;
  logic [31:0] output_RNSint [c_NO];

  int n_checks;
  int n_errors;

  fast_bconv_single #(
    .IN_BASIS_LEN (c_NI),
    .OUT_BASIS_LEN(c_NO),
    .IN_BASIS     (c_QB),
    .OUT_BASIS    (c_BB),
    .ZiLUT        (c_ZB),
    .YMODB        (c_YB)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .input_RNSint (input_RNSint),
    .out_valid    (out_valid),
    .output_RNSint(output_RNSint)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: integer Fast-BConv via q/q_i = {143, 91, 77}.
  function automatic void model(input longint xr [c_NI], output longint c [c_NO]);
    longint qhat [c_NI];
    longint s;
    qhat = '{143, 91, 77};
    s = 0;
    for (int i = 0; i < c_NI; i++) s += ((xr[i] * c_ZB[i]) % c_QB[i]) * qhat[i];
    for (int j = 0; j < c_NO; j++) c[j] = s % c_BB[j];
  endfunction

  task automatic start_conv(input logic [31:0] x0, x1, x2, input bit sync_neg);
    if (sync_neg) @(negedge clk);
    input_RNSint[0] = x0;
    input_RNSint[1] = x1;
    input_RNSint[2] = x2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int lat;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check({tag, "_latency"}, lat, c_LAT);
  endtask

  task automatic check_outputs(input string tag, input longint e [c_NO]);
    for (int j = 0; j < c_NO; j++)
      check($sformatf("%s_out%0d", tag, j), output_RNSint[j], e[j]);
  endtask

  task automatic check_pulse_end(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_pulse_width"}, out_valid, 0);
  endtask

  initial begin
    longint e [c_NO];
    longint xr [c_NI];
    longint first_out [c_NO];
    int cnt;
    int xv;

    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    input_RNSint = '{default: '0};

    // Reset state
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check_outputs("rst", '{0, 0, 0, 0, 0});
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_out_valid", out_valid, 0);

    // X = 100: sum a_i*qhat_i = 1101
    start_conv(32'd2, 32'd1, 32'd9, 1'b1);
    wait_result("x100");
    check_outputs("x100", '{2, 1, 9, 13, 18});
    check_pulse_end("x100");

    start_conv(32'd0, 32'd0, 32'd0, 1'b1);
    wait_result("zero");
    check_outputs("zero", '{0, 0, 0, 0, 0});
    check_pulse_end("zero");

    // x_i = q_i - 1 (X = 1000)
    start_conv(32'd6, 32'd10, 32'd12, 1'b1);
    wait_result("max");
    check_outputs("max", '{6, 10, 12, 14, 12});
    check_pulse_end("max");

    // X = 500: sum = 1501 = 19*79 exercises an exact-modulus wrap
    start_conv(32'd3, 32'd5, 32'd6, 1'b1);
    wait_result("x500");
    check_outputs("x500", '{3, 5, 6, 5, 0});
    check_pulse_end("x500");
    repeat (6) @(posedge clk);
    #1;
    check_outputs("hold", '{3, 5, 6, 5, 0});

    for (int r = 0; r < 20; r++) begin
      xv = int'($urandom_range(0, 1000));
      xr = '{longint'(xv % 7), longint'(xv % 11), longint'(xv % 13)};
      model(xr, e);
      start_conv(32'(xr[0]), 32'(xr[1]), 32'(xr[2]), 1'b1);
      wait_result($sformatf("rnd%0d", r));
      check_outputs($sformatf("rnd%0d", r), e);
    end

    // Back-to-back: new request accepted in the out_valid cycle
    start_conv(32'd2, 32'd1, 32'd9, 1'b1);
    wait_result("b2b_a");
    start_conv(32'd6, 32'd10, 32'd12, 1'b0);
    wait_result("b2b_b");
    check_outputs("b2b_b", '{6, 10, 12, 14, 12});

    // Busy: second request mid-conversion is ignored
    start_conv(32'd2, 32'd1, 32'd9, 1'b1);
    cnt = 0;
    first_out = '{default: -1};
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (cnt == 0) for (int j = 0; j < c_NO; j++) first_out[j] = output_RNSint[j];
        cnt++;
      end
      if (n == 2) begin
        input_RNSint = '{32'd3, 32'd5, 32'd6};
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    check("busy_pulse_count", cnt, 1);
    for (int j = 0; j < c_NO; j++) begin
      longint exp_b [c_NO];
      exp_b = '{2, 1, 9, 13, 18};
      check($sformatf("busy_out%0d", j), first_out[j], exp_b[j]);
    end

    // Reset mid-conversion aborts and clears outputs
    start_conv(32'd3, 32'd5, 32'd6, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check_outputs("abort", '{0, 0, 0, 0, 0});
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) cnt++;
    end
    check("abort_no_pulse", cnt, 0);
    start_conv(32'd6, 32'd10, 32'd12, 1'b1);
    wait_result("post_abort");
    check_outputs("post_abort", '{6, 10, 12, 14, 12});

    // Out-of-contract residues must still complete
    start_conv(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_result("ooc");
    start_conv(32'd3, 32'd5, 32'd6, 1'b1);
    wait_result("post_ooc");
    check_outputs("post_ooc", '{3, 5, 6, 5, 0});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
